// File: rtl/rd53_cmd_decoder.sv
// RD53A TTC command decoder: classifies aligned 16-bit frames, collects command payloads,
// and emits registered command, trigger and sync events plus a saturating protocol-error count.
//
// state   | meaning
// IDLE    | waiting for a header, trigger, sync or noop frame
// COLLECT | header seen, gathering payload frames (busy=1)
// DONE    | command complete, cmd_valid=1 for one cycle; frames handled as in IDLE
module rd53_cmd_decoder #(
    parameter int TIMEOUT = 64,
    parameter int ERR_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      data_in,
    input  logic             data_valid,
    output logic             cmd_valid,
    output logic [3:0]       cmd_type,
    output logic [19:0]      cmd_payload,
    output logic             trig_valid,
    output logic [3:0]       trig_pattern,
    output logic [4:0]       trig_tag,
    output logic             sync_pulse,
    output logic             busy,
    output logic [ERR_W-1:0] err_count
);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [15:0] SYNC_WORD = 16'h817E;
    localparam logic [15:0] NOOP_WORD = 16'h6969;

    localparam logic [7:0] DATA_ROM [32] = '{
        8'h6A, 8'h6C, 8'h71, 8'h72, 8'h74, 8'h8B, 8'h8D, 8'h8E,
        8'h93, 8'h95, 8'h96, 8'h99, 8'h9A, 8'h9C, 8'hA3, 8'hA5,
        8'hA6, 8'hA9, 8'hAA, 8'hAC, 8'hB1, 8'hB2, 8'hB4, 8'hC3,
        8'hC5, 8'hC6, 8'hC9, 8'hCA, 8'hCC, 8'hD1, 8'hD2, 8'hD4};
    localparam logic [7:0] TRIG_ROM [15] = '{
        8'h2B, 8'h2D, 8'h2E, 8'h33, 8'h35, 8'h36, 8'h39, 8'h3A,
        8'h3C, 8'h4B, 8'h4D, 8'h4E, 8'h53, 8'h55, 8'h56};

    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

    // {valid, value}
    function automatic logic [5:0] data_lookup(input logic [7:0] s);
        data_lookup = '0;
        for (int i = 0; i < 32; i++)
            if (DATA_ROM[i] == s) data_lookup = {1'b1, 5'(i)};
    endfunction

    // {valid, pattern}; pattern is 1-based
    function automatic logic [4:0] trig_lookup(input logic [7:0] s);
        trig_lookup = '0;
        for (int i = 0; i < 15; i++)
            if (TRIG_ROM[i] == s) trig_lookup = {1'b1, 4'(i + 1)};
    endfunction

    // {valid, type[3:0], payload frames[1:0]}
    function automatic logic [6:0] hdr_lookup(input logic [15:0] w);
        case (w)
            16'h5A5A: hdr_lookup = {1'b1, 4'd0, 2'd0};
            16'h5959: hdr_lookup = {1'b1, 4'd1, 2'd0};
            16'h5C5C: hdr_lookup = {1'b1, 4'd2, 2'd1};
            16'h6363: hdr_lookup = {1'b1, 4'd3, 2'd2};
            16'h6666: hdr_lookup = {1'b1, 4'd4, 2'd2};
            16'h6565: hdr_lookup = {1'b1, 4'd5, 2'd1};
            default:  hdr_lookup = '0;
        endcase
    endfunction

    state_t        state, state_n;
    logic [1:0]    frames_left, frames_left_n;
    logic          first, first_n;
    logic [9:0]    acc, acc_n;
    logic [3:0]    pend_type, pend_type_n;
    logic [TW-1:0] tmr, tmr_n;
    logic [3:0]    cmd_type_n;
    logic [19:0]   cmd_payload_n;
    logic          trig_valid_n, sync_n;
    logic [3:0]    trig_pattern_n;
    logic [4:0]    trig_tag_n;
    logic [ERR_W-1:0] err_count_n;
    logic          err, reload;
    logic [5:0]    hi_sym, lo_sym;
    logic [4:0]    trg;
    logic [6:0]    hdr;

    assign hi_sym = data_lookup(data_in[15:8]);
    assign lo_sym = data_lookup(data_in[7:0]);
    assign trg    = trig_lookup(data_in[15:8]);
    assign hdr    = hdr_lookup(data_in);

    assign busy      = (state == COLLECT);
    assign cmd_valid = (state == DONE);

    always_comb begin
        state_n        = (state == DONE) ? IDLE : state;
        frames_left_n  = frames_left;
        first_n        = first;
        acc_n          = acc;
        pend_type_n    = pend_type;
        tmr_n          = tmr;
        cmd_type_n     = cmd_type;
        cmd_payload_n  = cmd_payload;
        trig_valid_n   = 1'b0;
        trig_pattern_n = trig_pattern;
        trig_tag_n     = trig_tag;
        sync_n         = 1'b0;
        err            = 1'b0;
        reload         = 1'b0;

        if (data_valid && data_in == SYNC_WORD) begin
            sync_n = 1'b1;
        end else if (data_valid && data_in != NOOP_WORD) begin
            if (trg[4]) begin
                if (lo_sym[5]) begin
                    trig_valid_n   = 1'b1;
                    trig_pattern_n = trg[3:0];
                    trig_tag_n     = lo_sym[4:0];
                end else begin
                    err = 1'b1;
                end
            end else if (hdr[6]) begin
                // a header inside a collection aborts it, then starts afresh
                err    = (state == COLLECT);
                reload = 1'b1;
                if (hdr[1:0] == 2'd0) begin
                    state_n       = DONE;
                    cmd_type_n    = hdr[5:2];
                    cmd_payload_n = '0;
                end else begin
                    state_n       = COLLECT;
                    frames_left_n = hdr[1:0];
                    pend_type_n   = hdr[5:2];
                    first_n       = 1'b1;
                    acc_n         = '0;
                end
            end else if (state == COLLECT && hi_sym[5] && lo_sym[5]) begin
                reload = 1'b1;
                if (frames_left == 2'd1) begin
                    state_n       = DONE;
                    cmd_type_n    = pend_type;
                    cmd_payload_n = first ? {hi_sym[4:0], lo_sym[4:0], 10'd0}
                                          : {acc, hi_sym[4:0], lo_sym[4:0]};
                end else begin
                    frames_left_n = frames_left - 2'd1;
                    first_n       = 1'b0;
                    acc_n         = {hi_sym[4:0], lo_sym[4:0]};
                end
            end else begin
                err     = 1'b1;
                state_n = IDLE;
            end
        end

        // only payload frames and headers restart the idle timer
        if (reload) begin
            tmr_n = TW'(TIMEOUT - 1);
        end else if (state == COLLECT && state_n == COLLECT) begin
            if (tmr == '0) begin
                err     = 1'b1;
                state_n = IDLE;
            end else begin
                tmr_n = tmr - 1'b1;
            end
        end

        err_count_n = (err && err_count != '1) ? err_count + 1'b1 : err_count;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            frames_left  <= '0;
            first        <= 1'b0;
            acc          <= '0;
            pend_type    <= '0;
            tmr          <= '0;
            cmd_type     <= '0;
            cmd_payload  <= '0;
            trig_valid   <= 1'b0;
            trig_pattern <= '0;
            trig_tag     <= '0;
            sync_pulse   <= 1'b0;
            err_count    <= '0;
        end else begin
            state        <= state_n;
            frames_left  <= frames_left_n;
            first        <= first_n;
            acc          <= acc_n;
            pend_type    <= pend_type_n;
            tmr          <= tmr_n;
            cmd_type     <= cmd_type_n;
            cmd_payload  <= cmd_payload_n;
            trig_valid   <= trig_valid_n;
            trig_pattern <= trig_pattern_n;
            trig_tag     <= trig_tag_n;
            sync_pulse   <= sync_n;
            err_count    <= err_count_n;
        end
    end

endmodule
